// File: rtl/dmem_uart_loader_if.sv
// Bus between the UART byte source / controller and the data-memory loader.
// The checksum signal exists only when LOADER_CHECKSUM_EN is defined.
interface dmem_uart_loader_if;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        busy;
  logic        done;
  logic [14:0] word_count;
  logic        overflow;
  logic [1:0]  dbg_state;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  // rx_valid carries one byte per asserted cycle with no back-pressure:
  // the loader must take every byte presented while it is in LOAD.
  modport slave (
    input  start, rx_valid, rx_data,
    output mem_write, mem_address, mem_write_data,
    output busy, done, word_count, overflow, dbg_state
`ifdef LOADER_CHECKSUM_EN
    , output checksum
`endif
  );

  modport master (
    output start, rx_valid, rx_data,
    input  mem_write, mem_address, mem_write_data,
    input  busy, done, word_count, overflow, dbg_state
`ifdef LOADER_CHECKSUM_EN
    , input checksum
`endif
  );
endinterface

// File: rtl/dmem_uart_loader.sv
// Assembles UART bytes into little-endian words and writes them to data memory,
// ending on an idle timeout. Optional byte checksum under LOADER_CHECKSUM_EN.
module dmem_uart_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          WORD_LIMIT     = 16384,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic               clock,
  input  logic               reset,
  dmem_uart_loader_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  state_t      r_state,          w_state_n;
  logic [1:0]  r_byte_idx,       w_byte_idx_n;
  logic [TW-1:0] r_timer,        w_timer_n;
  logic        r_armed,          w_armed_n;
  logic [23:0] r_asm,            w_asm_n;
  logic        r_mem_write,      w_mem_write_n;
  logic [31:0] r_mem_address,    w_mem_address_n;
  logic [31:0] r_mem_write_data, w_mem_write_data_n;
  logic        r_busy,           w_busy_n;
  logic        r_done,           w_done_n;
  logic [14:0] r_word_count,     w_word_count_n;
  logic        r_overflow,       w_overflow_n;
  logic [31:0] w_full_word;
  logic [31:0] w_partial_word;
  logic [31:0] w_word_addr;
  logic        w_at_limit;
  logic        w_timer_expired;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_checksum,       w_checksum_n;

  function automatic logic [7:0] byte_sum(input logic [31:0] w);
    return w[7:0] + w[15:8] + w[23:16] + w[31:24];
  endfunction
`endif

  assign w_full_word     = {bus.rx_data, r_asm};
  assign w_word_addr     = BASE_ADDR + {15'd0, r_word_count, 2'b00};
  assign w_at_limit      = (r_word_count == 15'(WORD_LIMIT));
  assign w_timer_expired = (r_timer == TW'(TIMEOUT_CYCLES - 1));

  // Lanes above byte_idx may hold bytes of the previous word; zero them.
  always_comb begin
    w_partial_word = 32'd0;
    case (r_byte_idx)
      2'd1:    w_partial_word = {24'd0, r_asm[7:0]};
      2'd2:    w_partial_word = {16'd0, r_asm[15:0]};
      2'd3:    w_partial_word = {8'd0, r_asm};
      default: w_partial_word = 32'd0;
    endcase
  end

  always_comb begin
    w_state_n          = r_state;
    w_byte_idx_n       = r_byte_idx;
    w_timer_n          = r_timer;
    w_armed_n          = r_armed;
    w_asm_n            = r_asm;
    w_mem_write_n      = 1'b0;
    w_mem_address_n    = r_mem_address;
    w_mem_write_data_n = r_mem_write_data;
    w_busy_n           = r_busy;
    w_done_n           = r_done;
    w_word_count_n     = r_word_count;
    w_overflow_n       = r_overflow;
`ifdef LOADER_CHECKSUM_EN
    w_checksum_n       = r_checksum;
`endif
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_n      = S_LOAD;
          w_busy_n       = 1'b1;
          w_done_n       = 1'b0;
          w_word_count_n = 15'd0;
          w_overflow_n   = 1'b0;
          w_byte_idx_n   = 2'd0;
          w_timer_n      = '0;
          w_armed_n      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          w_checksum_n   = 8'd0;
`endif
        end
      end
      S_LOAD: begin
        if (bus.rx_valid) begin
          w_timer_n = '0;
          w_armed_n = 1'b1;
          if (w_at_limit) begin
            w_overflow_n = 1'b1;
          end else if (r_byte_idx == 2'd3) begin
            w_mem_write_n      = 1'b1;
            w_mem_write_data_n = w_full_word;
            w_mem_address_n    = w_word_addr;
            w_word_count_n     = r_word_count + 15'd1;
            w_byte_idx_n       = 2'd0;
`ifdef LOADER_CHECKSUM_EN
            w_checksum_n       = r_checksum + byte_sum(w_full_word);
`endif
          end else begin
            w_asm_n[8*r_byte_idx +: 8] = bus.rx_data;
            w_byte_idx_n               = r_byte_idx + 2'd1;
          end
        end else if (r_armed) begin
          if (w_timer_expired) begin
            w_timer_n = '0;
            if (r_byte_idx == 2'd0) begin
              w_state_n = S_DONE;
              w_busy_n  = 1'b0;
              w_done_n  = 1'b1;
            end else begin
              // The partial word is written while FLUSH is the current state.
              w_state_n          = S_FLUSH;
              w_mem_write_n      = 1'b1;
              w_mem_write_data_n = w_partial_word;
              w_mem_address_n    = w_word_addr;
              w_word_count_n     = r_word_count + 15'd1;
`ifdef LOADER_CHECKSUM_EN
              w_checksum_n       = r_checksum + byte_sum(w_partial_word);
`endif
            end
          end else begin
            w_timer_n = r_timer + TW'(1);
          end
        end
      end
      S_FLUSH: begin
        w_state_n    = S_DONE;
        w_byte_idx_n = 2'd0;
        w_busy_n     = 1'b0;
        w_done_n     = 1'b1;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_byte_idx       <= 2'd0;
      r_timer          <= '0;
      r_armed          <= 1'b0;
      r_asm            <= 24'd0;
      r_mem_write      <= 1'b0;
      r_mem_address    <= 32'd0;
      r_mem_write_data <= 32'd0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_word_count     <= 15'd0;
      r_overflow       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_checksum       <= 8'd0;
`endif
    end else begin
      r_state          <= w_state_n;
      r_byte_idx       <= w_byte_idx_n;
      r_timer          <= w_timer_n;
      r_armed          <= w_armed_n;
      r_asm            <= w_asm_n;
      r_mem_write      <= w_mem_write_n;
      r_mem_address    <= w_mem_address_n;
      r_mem_write_data <= w_mem_write_data_n;
      r_busy           <= w_busy_n;
      r_done           <= w_done_n;
      r_word_count     <= w_word_count_n;
      r_overflow       <= w_overflow_n;
`ifdef LOADER_CHECKSUM_EN
      r_checksum       <= w_checksum_n;
`endif
    end
  end

  assign bus.mem_write      = r_mem_write;
  assign bus.mem_address    = r_mem_address;
  assign bus.mem_write_data = r_mem_write_data;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.word_count     = r_word_count;
  assign bus.overflow       = r_overflow;
  assign bus.dbg_state      = r_state;
`ifdef LOADER_CHECKSUM_EN
  assign bus.checksum       = r_checksum;
`endif
endmodule

// File: tb/tb_dmem_uart_loader.sv
// Directed bench for dmem_uart_loader: a vector table for the basic write path
// and hand-written sequences for timeout, flush, word limit and reset corners.
module tb_dmem_uart_loader;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          LIM  = 2;
  localparam int          TO   = 16;

  logic clock;
  logic reset;
  int   n_total;
  int   n_pass;
  logic [63:0] exp_q[$];

  dmem_uart_loader_if bus ();

  dmem_uart_loader #(
    .BASE_ADDR      (BASE),
    .WORD_LIMIT     (LIM),
    .TIMEOUT_CYCLES (TO)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        rst;
    logic        st;
    logic        v;
    logic [7:0]  d;
    logic        mw;
    logic        busy;
    logic        done;
    logic [14:0] wc;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic chk_st(input string name, input logic mw, input logic busy,
                        input logic done, input logic ovf, input logic [14:0] wc);
    chk(name, {45'd0, bus.mem_write, bus.busy, bus.done, bus.overflow, bus.word_count},
        {45'd0, mw, busy, done, ovf, wc});
  endtask

  // driver: inputs change at the falling edge, outputs are read one cycle later
  task automatic step(input logic r, input logic s, input logic v, input logic [7:0] d);
    reset        = r;
    bus.start    = s;
    bus.rx_valid = v;
    bus.rx_data  = d;
    @(negedge clock);
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // scoreboard: every write pulse must match the next expected write
  always @(negedge clock) begin
    if (bus.mem_write === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr %h data %h, required no write",
                 bus.mem_address, bus.mem_write_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({bus.mem_address, bus.mem_write_data} === e) n_pass++;
        else $display("FAIL write: got %h/%h required %h/%h",
                      bus.mem_address, bus.mem_write_data, e[63:32], e[31:0]);
      end
    end
  end

  vec_t vecs[8];

  initial begin
    n_total      = 0;
    n_pass       = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    vecs[0] = '{rst:1'b1, st:1'b0, v:1'b0, d:8'h00, mw:1'b0, busy:1'b0, done:1'b0, wc:15'd0, addr:32'h0, data:32'h0};
    vecs[1] = '{rst:1'b0, st:1'b0, v:1'b1, d:8'hEE, mw:1'b0, busy:1'b0, done:1'b0, wc:15'd0, addr:32'h0, data:32'h0};
    vecs[2] = '{rst:1'b0, st:1'b1, v:1'b0, d:8'h00, mw:1'b0, busy:1'b1, done:1'b0, wc:15'd0, addr:32'h0, data:32'h0};
    vecs[3] = '{rst:1'b0, st:1'b0, v:1'b1, d:8'h78, mw:1'b0, busy:1'b1, done:1'b0, wc:15'd0, addr:32'h0, data:32'h0};
    vecs[4] = '{rst:1'b0, st:1'b0, v:1'b1, d:8'h56, mw:1'b0, busy:1'b1, done:1'b0, wc:15'd0, addr:32'h0, data:32'h0};
    vecs[5] = '{rst:1'b0, st:1'b0, v:1'b1, d:8'h34, mw:1'b0, busy:1'b1, done:1'b0, wc:15'd0, addr:32'h0, data:32'h0};
    vecs[6] = '{rst:1'b0, st:1'b0, v:1'b1, d:8'h12, mw:1'b1, busy:1'b1, done:1'b0, wc:15'd1, addr:BASE, data:32'h1234_5678};
    vecs[7] = '{rst:1'b0, st:1'b0, v:1'b0, d:8'h00, mw:1'b0, busy:1'b1, done:1'b0, wc:15'd1, addr:BASE, data:32'h1234_5678};

    @(negedge clock);
    // basic word write, rx ignored in IDLE
    push_wr(BASE, 32'h1234_5678);
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].rst, vecs[i].st, vecs[i].v, vecs[i].d);
      chk($sformatf("vec%0d", i),
          {bus.mem_write, bus.busy, bus.done, bus.overflow, bus.word_count, bus.mem_address, bus.mem_write_data},
          {vecs[i].mw, vecs[i].busy, vecs[i].done, 1'b0, vecs[i].wc, vecs[i].addr, vecs[i].data});
    end

    // back-to-back bytes, clean timeout
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk_st("t2_reset", 1'b0, 1'b0, 1'b0, 1'b0, 15'd0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    push_wr(BASE, 32'h0403_0201);
    push_wr(BASE + 32'd4, 32'h0807_0605);
    for (int i = 1; i <= 8; i++) send(8'(i));
    chk_st("t2_last_byte", 1'b1, 1'b1, 1'b0, 1'b0, 15'd2);
    idle(TO - 1);
    chk_st("t2_before_timeout", 1'b0, 1'b1, 1'b0, 1'b0, 15'd2);
    idle(1);
    chk_st("t2_done", 1'b0, 1'b0, 1'b1, 1'b0, 15'd2);

    // partial word flushed on timeout
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    push_wr(BASE, 32'h0403_0201);
    push_wr(BASE + 32'd4, 32'h0000_0605);
    for (int i = 1; i <= 6; i++) send(8'(i));
    chk_st("t3_after_bytes", 1'b0, 1'b1, 1'b0, 1'b0, 15'd1);
    idle(TO - 1);
    chk_st("t3_before_timeout", 1'b0, 1'b1, 1'b0, 1'b0, 15'd1);
    idle(1);
    chk_st("t3_flush_pulse", 1'b1, 1'b1, 1'b0, 1'b0, 15'd2);
    chk("t3_flush_data", bus.mem_write_data, 32'h0000_0605);
    idle(1);
    chk_st("t3_done", 1'b0, 1'b0, 1'b1, 1'b0, 15'd2);

    // word limit: overflow, discards, start ignored while loading
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    push_wr(BASE, 32'h1413_1211);
    push_wr(BASE + 32'd4, 32'h1817_1615);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, (i == 4), 1'b1, 8'h11 + 8'(i));
      if (i == 7) chk_st("t4_limit_reached", 1'b1, 1'b1, 1'b0, 1'b0, 15'd2);
      if (i == 8) chk_st("t4_overflow", 1'b0, 1'b1, 1'b0, 1'b1, 15'd2);
    end
    idle(TO - 1);
    chk_st("t4_before_timeout", 1'b0, 1'b1, 1'b0, 1'b1, 15'd2);
    idle(1);
    chk_st("t4_done", 1'b0, 1'b0, 1'b1, 1'b1, 15'd2);
    idle(3);
    chk_st("t4_done_held", 1'b0, 1'b0, 1'b1, 1'b1, 15'd2);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk_st("t4_restart", 1'b0, 1'b1, 1'b0, 1'b0, 15'd0);

    // reset mid-word, then a fresh load
    send(8'hAA);
    send(8'hBB);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk_st("t5_reset", 1'b0, 1'b0, 1'b0, 1'b0, 15'd0);
    chk("t5_reset_bus", {bus.mem_address, bus.mem_write_data}, 64'd0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    push_wr(BASE, 32'hDDCC_BBAA);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    send(8'hDD);
    chk_st("t5_write", 1'b1, 1'b1, 1'b0, 1'b0, 15'd1);
    // a byte on the would-be expiry cycle counts as activity
    idle(TO - 1);
    send(8'h01);
    chk_st("t5_no_timeout", 1'b0, 1'b1, 1'b0, 1'b0, 15'd1);
    push_wr(BASE + 32'd4, 32'h0000_0001);
    idle(TO - 1);
    chk_st("t5_timer_restarted", 1'b0, 1'b1, 1'b0, 1'b0, 15'd1);
    idle(1);
    chk_st("t5_flush", 1'b1, 1'b1, 1'b0, 1'b0, 15'd2);
    idle(1);
    chk_st("t5_done", 1'b0, 1'b0, 1'b1, 1'b0, 15'd2);

`ifdef LOADER_CHECKSUM_EN
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    push_wr(BASE, 32'h0000_02FF);
    send(8'hFF);
    send(8'h02);
    send(8'h00);
    send(8'h00);
    chk("cs_after_write", bus.checksum, 8'h01);
    idle(TO);
    chk("cs_held_done", {bus.done, bus.checksum}, {1'b1, 8'h01});
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("cs_cleared_start", bus.checksum, 8'h00);
`endif

    idle(2);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
